ship_placement_ctrl: RTL and testbench

Per-player ship placement controller. It sits directly upstream of the VGA renderer and produces the 36-bit one-hot placement cursor and the placed-ships bitmap that the renderer draws on the placement grid. It consumes debounced button levels and an enable from the top-level game FSM, and reports completion so that FSM can advance to the next player's placement or to the attack phase. One instance is used per player.

---
 rtl/battleship_pkg.sv | 36 +++
 rtl/btn_edge_detect.sv | 23 ++
 rtl/ship_placement_ctrl.sv | 122 ++++++++++++
 tb/tb_ship_placement_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared battleship definitions: grid defaults, game-state and placement FSM encodings,
// button bit positions and the cell-index helper.
package battleship_pkg;

    localparam int unsigned DefGridSize = 6;
    localparam int unsigned DefCells    = DefGridSize * DefGridSize;
    localparam int unsigned DefNumShips = 5;

    typedef enum logic [2:0] {
        GameP1Placing = 3'b000,
        GameP2Placing = 3'b001,
        GameP1Attack  = 3'b010,
        GameP2Attack  = 3'b011,
        GameP1Wins    = 3'b100,
        GameP2Wins    = 3'b101
    } game_state_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPlacing = 2'b01,
        StDone    = 2'b10
    } place_state_e;

    // Bit positions within the packed 5-bit button vector.
    localparam int unsigned BtnRight = 0;
    localparam int unsigned BtnLeft  = 1;
    localparam int unsigned BtnDown  = 2;
    localparam int unsigned BtnUp    = 3;
    localparam int unsigned BtnPlace = 4;

    function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col,
                                              input int unsigned grid);
        return 6'({29'd0, row} * grid + {29'd0, col});
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector over a vector of synchronised button levels.
module btn_edge_detect #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= btn;
        end
    end

    assign rise = btn & ~prev_q;

endmodule

// File: rtl/ship_placement_ctrl.sv
// Per-player ship placement: wrapping cursor movement, single-cell ship placement with
// occupied-cell rejection, and a done level once all ships are down.
module ship_placement_ctrl #(
    parameter int unsigned GRID_SIZE = battleship_pkg::DefGridSize,
    parameter int unsigned NUM_SHIPS = battleship_pkg::DefNumShips
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           btn_up,
    input  logic                           btn_down,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic                           btn_place,
    output logic [GRID_SIZE*GRID_SIZE-1:0] placement_cursor,
    output logic [GRID_SIZE*GRID_SIZE-1:0] placed_ships,
    output logic [2:0]                     ship_count,
    output logic                           placement_done,
    output logic                           place_reject
);

    import battleship_pkg::*;

    localparam int unsigned NumCells = GRID_SIZE * GRID_SIZE;
    localparam logic [2:0]  MaxPos   = 3'(GRID_SIZE - 1);
    localparam logic [2:0]  Target   = 3'(NUM_SHIPS);

    logic [4:0] btn_level;
    logic [4:0] act;

    place_state_e        state_q, state_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic [5:0]          cell_q, cell_d;
    logic [NumCells-1:0] ships_q, ships_d;
    logic [2:0]          count_q, count_d;
    logic                reject_q, reject_d;

    assign btn_level = {btn_place, btn_up, btn_down, btn_left, btn_right};

    btn_edge_detect #(
        .WIDTH(5)
    ) u_btn_edge (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_level),
        .rise (act)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            row_q    <= '0;
            col_q    <= '0;
            cell_q   <= '0;
            ships_q  <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            cell_q   <= cell_d;
            ships_q  <= ships_d;
            count_q  <= count_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        ships_d  = ships_q;
        count_d  = count_q;
        reject_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StPlacing;
            end
            StPlacing: begin
                // Priority chain: place > up > down > left > right, one action per cycle.
                if (!enable) begin
                    state_d = StIdle;
                end else if (act[BtnPlace]) begin
                    if (ships_q[cell_q]) begin
                        reject_d = 1'b1;
                    end else begin
                        ships_d[cell_q] = 1'b1;
                        count_d         = count_q + 3'd1;
                        if (count_q + 3'd1 == Target) state_d = StDone;
                    end
                end else if (act[BtnUp]) begin
                    row_d = (row_q == 3'd0) ? MaxPos : row_q - 3'd1;
                end else if (act[BtnDown]) begin
                    row_d = (row_q == MaxPos) ? 3'd0 : row_q + 3'd1;
                end else if (act[BtnLeft]) begin
                    col_d = (col_q == 3'd0) ? MaxPos : col_q - 3'd1;
                end else if (act[BtnRight]) begin
                    col_d = (col_q == MaxPos) ? 3'd0 : col_q + 3'd1;
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase

        cell_d = cell_index(row_d, col_d, GRID_SIZE);
    end

    always_comb begin
        placement_cursor = '0;
        if (state_q == StPlacing) placement_cursor[cell_q] = 1'b1;
    end

    assign placed_ships   = ships_q;
    assign ship_count     = count_q;
    assign placement_done = (state_q == StDone);
    assign place_reject   = reject_q;

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Directed bench for ship_placement_ctrl with hand-computed expectations.
module tb_ship_placement_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        btn_up, btn_down, btn_left, btn_right, btn_place;
    logic [35:0] placement_cursor;
    logic [35:0] placed_ships;
    logic [2:0]  ship_count;
    logic        placement_done;
    logic        place_reject;

    int checks   = 0;
    int failures = 0;

    ship_placement_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .btn_up          (btn_up),
        .btn_down        (btn_down),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_place       (btn_place),
        .placement_cursor(placement_cursor),
        .placed_ships    (placed_ships),
        .ship_count      (ship_count),
        .placement_done  (placement_done),
        .place_reject    (place_reject)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_btns(input logic [4:0] m);
        {btn_place, btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    // One-cycle press followed by one released cycle so the next press is a fresh edge.
    task automatic press(input logic [4:0] m);
        set_btns(m);
        tick();
        set_btns(5'b0);
        tick();
    endtask

    localparam logic [4:0] P = 5'b10000, U = 5'b01000, D = 5'b00100, L = 5'b00010,
                           R = 5'b00001;

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        set_btns(5'b0);
        tick();
        tick();
        chk("rst_cursor", placement_cursor, 36'h0);
        chk("rst_ships", placed_ships, 36'h0);
        chk("rst_count", 36'(ship_count), 36'd0);
        chk("rst_done", 36'(placement_done), 36'd0);
        chk("rst_reject", 36'(place_reject), 36'd0);

        reset = 1'b0;
        tick();
        chk("entry_cursor", placement_cursor, 36'h1);
        chk("entry_ships", placed_ships, 36'h0);
        chk("entry_count", 36'(ship_count), 36'd0);
        chk("entry_done", 36'(placement_done), 36'd0);

        press(L);
        chk("left_wrap", placement_cursor, 36'h1 << 5);
        press(U);
        chk("up_wrap", placement_cursor, 36'h1 << 35);

        set_btns(R);
        tick();
        chk("right_first", placement_cursor, 36'h1 << 30);
        repeat (9) tick();
        chk("right_held", placement_cursor, 36'h1 << 30);
        set_btns(5'b0);
        tick();

        press(D);
        chk("down_wrap", placement_cursor, 36'h1);
        press(P);
        chk("place0_ships", placed_ships, 36'h1);
        chk("place0_count", 36'(ship_count), 36'd1);

        set_btns(P);
        tick();
        chk("reject_high", 36'(place_reject), 36'd1);
        set_btns(5'b0);
        tick();
        chk("reject_low", 36'(place_reject), 36'd0);
        chk("reject_ships", placed_ships, 36'h1);
        chk("reject_count", 36'(ship_count), 36'd1);

        for (int i = 1; i <= 4; i++) begin
            press(R);
            press(P);
        end
        chk("five_ships", placed_ships, 36'h1F);
        chk("five_count", 36'(ship_count), 36'd5);
        chk("five_done", 36'(placement_done), 36'd1);
        chk("five_cursor", placement_cursor, 36'h0);

        press(P);
        press(L);
        enable = 1'b0;
        tick();
        tick();
        chk("done_ships", placed_ships, 36'h1F);
        chk("done_count", 36'(ship_count), 36'd5);
        chk("done_level", 36'(placement_done), 36'd1);
        chk("done_reject", 36'(place_reject), 36'd0);

        // Asynchronous reset mid-cycle.
        #2 reset = 1'b1;
        #1;
        chk("async_ships", placed_ships, 36'h0);
        chk("async_count", 36'(ship_count), 36'd0);
        chk("async_done", 36'(placement_done), 36'd0);
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        chk("reentry_cursor", placement_cursor, 36'h1);

        press(D);
        press(D);
        press(R);
        press(R);
        press(R);
        chk("at_2_3", placement_cursor, 36'h1 << 15);
        press(U | L | P);
        chk("prio_ships", placed_ships, 36'h1 << 15);
        chk("prio_cursor", placement_cursor, 36'h1 << 15);
        chk("prio_count", 36'(ship_count), 36'd1);

        press(R);
        press(P);
        chk("two_ships", placed_ships, 36'h18000);
        chk("two_count", 36'(ship_count), 36'd2);

        enable = 1'b0;
        tick();
        chk("idle_cursor", placement_cursor, 36'h0);
        chk("idle_ships", placed_ships, 36'h18000);
        press(L);
        set_btns(R);
        tick();
        tick();
        enable = 1'b1;
        tick();
        tick();
        chk("restore_cursor", placement_cursor, 36'h1 << 16);
        chk("held_entry", placement_cursor, 36'h1 << 16);
        set_btns(5'b0);
        tick();
        chk("restore_count", 36'(ship_count), 36'd2);

        set_btns(P);
        tick();
        chk("reject2_high", 36'(place_reject), 36'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_kills_pulse", 36'(place_reject), 36'd0);
        chk("rst_clears_ships", placed_ships, 36'h0);
        set_btns(5'b0);
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
